// File: rtl/morse_decoder_param.sv
// Morse key decoder: synchronises and debounces a raw key, classifies presses
// as dot/dash, buffers up to MAX_SYM symbols and emits one ASCII character
// (with error flag) after a letter-gap timeout.
// Optional build macro MORSE_WORD_SPACE_EN: also emit a space (8'h20) once the
// key has stayed released for WORD_GAP cycles after the last release.
`timescale 1ns/1ps
module morse_decoder_param #(
   parameter int CNT_W        = 16,
   parameter int DEBOUNCE_CYC = 4,
   parameter int DOT_MIN      = 100,
   parameter int DASH_MIN     = 2000,
   parameter int LETTER_GAP   = 3000,
   parameter int WORD_GAP     = 7000,
   parameter int MAX_SYM      = 6
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         button,
   output logic [7:0]                   char_data,
   output logic                         char_valid,
   output logic                         char_err,
   output logic [$clog2(MAX_SYM+1)-1:0] sym_count,
   output logic                         busy
);

   localparam int CW  = $clog2(MAX_SYM + 1);
   localparam int DBW = $clog2(DEBOUNCE_CYC + 1);

   localparam logic [CNT_W-1:0] CNT_MAX      = '1;
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] DOT_MIN_C    = CNT_W'(DOT_MIN);
   localparam logic [CNT_W-1:0] DASH_MIN_C   = CNT_W'(DASH_MIN);
   localparam logic [CNT_W-1:0] LETTER_GAP_C = CNT_W'(LETTER_GAP);
   localparam logic [DBW-1:0]   DB_LAST      = DBW'(DEBOUNCE_CYC - 1);
   localparam logic [CW-1:0]    SYM_FULL     = CW'(MAX_SYM);
`ifdef MORSE_WORD_SPACE_EN
   localparam logic [CNT_W-1:0] WORD_GAP_C   = CNT_W'(WORD_GAP);
`endif

   // Parameter sanity checks at elaboration time.
   if (DASH_MIN <= DOT_MIN) begin : g_bad_dash
      $error("DASH_MIN must be greater than DOT_MIN");
   end
   if (WORD_GAP <= LETTER_GAP) begin : g_bad_word
      $error("WORD_GAP must be greater than LETTER_GAP");
   end
   if (MAX_SYM < 5) begin : g_bad_sym
      $error("MAX_SYM must be at least 5");
   end

   typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

   logic             sync1_q, sync1_d, sync2_q, sync2_d;
   logic             btn_db_q, btn_db_d;
   logic [DBW-1:0]   db_cnt_q, db_cnt_d;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
   logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [MAX_SYM-1:0] pat_q, pat_d;
   logic [CW-1:0]    sym_cnt_q, sym_cnt_d;
   logic             ovf_q, ovf_d;
   logic [7:0]       char_data_q, char_data_d;
   logic             char_valid_q, char_valid_d;
   logic             char_err_q, char_err_d;
   logic [8:0]       letter_w;
   logic             is_dash_w;
`ifdef MORSE_WORD_SPACE_EN
   logic             letter_done_q, letter_done_d;
`endif

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   // Returns {err, ascii}; the first symbol sits in the MSB of the len-wide pattern.
   function automatic logic [8:0] decode(input int len, input logic [4:0] pat, input logic ovf);
      logic [7:0] c;
      c = 8'h3F;
      if (!ovf) begin
         case (len)
            1: c = pat[0] ? "T" : "E";
            2: case (pat[1:0])
                  2'b00:   c = "I";
                  2'b01:   c = "A";
                  2'b10:   c = "N";
                  default: c = "M";
               endcase
            3: case (pat[2:0])
                  3'b000:  c = "S";
                  3'b001:  c = "U";
                  3'b010:  c = "R";
                  3'b011:  c = "W";
                  3'b100:  c = "D";
                  3'b101:  c = "K";
                  3'b110:  c = "G";
                  default: c = "O";
               endcase
            4: case (pat[3:0])
                  4'b0000: c = "H";
                  4'b0001: c = "V";
                  4'b0010: c = "F";
                  4'b0100: c = "L";
                  4'b0110: c = "P";
                  4'b0111: c = "J";
                  4'b1000: c = "B";
                  4'b1001: c = "X";
                  4'b1010: c = "C";
                  4'b1011: c = "Y";
                  4'b1100: c = "Z";
                  4'b1101: c = "Q";
                  default: c = 8'h3F;
               endcase
            5: case (pat)
                  5'b01111: c = "1";
                  5'b00111: c = "2";
                  5'b00011: c = "3";
                  5'b00001: c = "4";
                  5'b00000: c = "5";
                  5'b10000: c = "6";
                  5'b11000: c = "7";
                  5'b11100: c = "8";
                  5'b11110: c = "9";
                  5'b11111: c = "0";
                  default:  c = 8'h3F;
               endcase
            default: c = 8'h3F;
         endcase
      end
      return {(c == 8'h3F), c};
   endfunction

   assign letter_w  = decode(int'(sym_cnt_q), pat_q[4:0], ovf_q);
   assign is_dash_w = (press_cnt_q >= DASH_MIN_C);

   // Two-flop synchroniser and debounce: btn_db follows only after DEBOUNCE_CYC differing samples.
   always_comb begin
      sync1_d  = button;
      sync2_d  = sync1_q;
      btn_db_d = btn_db_q;
      db_cnt_d = '0;
      if (sync2_q != btn_db_q) begin
         if (db_cnt_q == DB_LAST) begin
            btn_db_d = sync2_q;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   // Press/gap state machine, symbol buffer and character emission.
   always_comb begin
      state_d      = state_q;
      press_cnt_d  = press_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      pat_d        = pat_q;
      sym_cnt_d    = sym_cnt_q;
      ovf_d        = ovf_q;
      char_data_d  = char_data_q;
      char_err_d   = char_err_q;
      char_valid_d = 1'b0;
`ifdef MORSE_WORD_SPACE_EN
      letter_done_d = letter_done_q;
`endif
      case (state_q)
         IDLE: begin
            // Level test so a press that overlapped an emission still starts here.
            if (btn_db_q) begin
               state_d     = PRESS;
               press_cnt_d = CNT_ONE;
            end
         end
         PRESS: begin
            if (btn_db_q) begin
               press_cnt_d = sat_inc(press_cnt_q);
            end else begin
               if (press_cnt_q >= DOT_MIN_C) begin
                  if (sym_cnt_q == SYM_FULL) begin
                     ovf_d = 1'b1;
                  end else begin
                     pat_d     = (pat_q << 1) | {{(MAX_SYM-1){1'b0}}, is_dash_w};
                     sym_cnt_d = sym_cnt_q + 1'b1;
                  end
               end
               gap_cnt_d = '0;
               state_d   = (sym_cnt_d != '0) ? GAP : IDLE;
            end
         end
         GAP: begin
`ifdef MORSE_WORD_SPACE_EN
            if (!letter_done_q && (gap_cnt_q == LETTER_GAP_C)) begin
               char_valid_d              = 1'b1;
               {char_err_d, char_data_d} = letter_w;
               pat_d                     = '0;
               sym_cnt_d                 = '0;
               ovf_d                     = 1'b0;
               letter_done_d             = 1'b1;
               gap_cnt_d                 = sat_inc(gap_cnt_q);
            end else if (letter_done_q && (gap_cnt_q == WORD_GAP_C)) begin
               char_valid_d  = 1'b1;
               char_data_d   = 8'h20;
               char_err_d    = 1'b0;
               letter_done_d = 1'b0;
               state_d       = IDLE;
            end else if (btn_db_q) begin
               letter_done_d = 1'b0;
               state_d       = PRESS;
               press_cnt_d   = CNT_ONE;
            end else begin
               gap_cnt_d = sat_inc(gap_cnt_q);
            end
`else
            if (gap_cnt_q == LETTER_GAP_C) begin
               char_valid_d              = 1'b1;
               {char_err_d, char_data_d} = letter_w;
               pat_d                     = '0;
               sym_cnt_d                 = '0;
               ovf_d                     = 1'b0;
               state_d                   = IDLE;
            end else if (btn_db_q) begin
               state_d     = PRESS;
               press_cnt_d = CNT_ONE;
            end else begin
               gap_cnt_d = sat_inc(gap_cnt_q);
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // All state registers; synchronous active-low reset clears everything.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         btn_db_q     <= 1'b0;
         db_cnt_q     <= '0;
         state_q      <= IDLE;
         press_cnt_q  <= '0;
         gap_cnt_q    <= '0;
         pat_q        <= '0;
         sym_cnt_q    <= '0;
         ovf_q        <= 1'b0;
         char_data_q  <= 8'h00;
         char_valid_q <= 1'b0;
         char_err_q   <= 1'b0;
`ifdef MORSE_WORD_SPACE_EN
         letter_done_q <= 1'b0;
`endif
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         btn_db_q     <= btn_db_d;
         db_cnt_q     <= db_cnt_d;
         state_q      <= state_d;
         press_cnt_q  <= press_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         pat_q        <= pat_d;
         sym_cnt_q    <= sym_cnt_d;
         ovf_q        <= ovf_d;
         char_data_q  <= char_data_d;
         char_valid_q <= char_valid_d;
         char_err_q   <= char_err_d;
`ifdef MORSE_WORD_SPACE_EN
         letter_done_q <= letter_done_d;
`endif
      end
   end

   assign char_data  = char_data_q;
   assign char_valid = char_valid_q;
   assign char_err   = char_err_q;
   assign sym_count  = sym_cnt_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_morse_decoder_param.sv
// Directed testbench for morse_decoder_param (default parameters).
`timescale 1ns/1ps
module tb_morse_decoder_param;

   logic       clk;
   logic       rst_n;
   logic       button;
   logic [7:0] char_data;
   logic       char_valid;
   logic       char_err;
   logic [2:0] sym_count;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int strobe_cnt = 0;
   logic [7:0] sd [4];
   logic       se [4];
   int         sc [4];
   int         rel;

   morse_decoder_param dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .button     (button),
      .char_data  (char_data),
      .char_valid (char_valid),
      .char_err   (char_err),
      .sym_count  (sym_count),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every char_valid strobe with its data, error flag and cycle.
   always @(negedge clk) begin
      if (char_valid === 1'b1) begin
         if (strobe_cnt < 4) begin
            sd[strobe_cnt] = char_data;
            se[strobe_cnt] = char_err;
            sc[strobe_cnt] = cyc;
         end
         strobe_cnt = strobe_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int n);
      button = 1'b1;
      cyc_n(n);
      button = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc_n(2);
      rst_n = 1'b1;
      cyc_n(1);
      strobe_cnt = 0;
   endtask

   initial begin
      button = 1'b0;
      rst_n  = 1'b0;
      cyc_n(3);
      chk("rst_data",  32'(char_data),  32'h00);
      chk("rst_valid", 32'(char_valid), 32'h0);
      chk("rst_err",   32'(char_err),   32'h0);
      chk("rst_sym",   32'(sym_count),  32'h0);
      chk("rst_busy",  32'(busy),       32'h0);
      rst_n = 1'b1;
      cyc_n(2);
      strobe_cnt = 0;

      // "A": dot, dash
      press(500);
      cyc_n(500);
      chk("A_sym1", 32'(sym_count), 32'd1);
      press(2500);
      rel = cyc;
      cyc_n(2990);
      chk("A_early", 32'(strobe_cnt), 32'd0);
      chk("A_sym2",  32'(sym_count),  32'd2);
      chk("A_busy",  32'(busy),       32'd1);
      cyc_n(110);
      chk("A_strobes", 32'(strobe_cnt), 32'd1);
      chk("A_data",    32'(sd[0]),      32'h41);
      chk("A_err",     32'(se[0]),      32'h0);
      chk("A_sym0",    32'(sym_count),  32'd0);
      chk("A_latency", 32'(sc[0] - rel), 32'd3008);

      // "0": five dashes
      do_reset();
      for (int i = 0; i < 5; i++) begin
         press(2500);
         if (i < 4) cyc_n(500);
      end
      cyc_n(3100);
      chk("0_strobes", 32'(strobe_cnt), 32'd1);
      chk("0_data",    32'(sd[0]),      32'h30);
      chk("0_err",     32'(se[0]),      32'h0);

      // "I" with a 50-cycle glitch between the dots
      do_reset();
      press(500);
      cyc_n(500);
      press(50);
      cyc_n(500);
      chk("I_glitch_sym", 32'(sym_count), 32'd1);
      press(500);
      cyc_n(100);
      chk("I_sym2", 32'(sym_count), 32'd2);
      cyc_n(3000);
      chk("I_strobes", 32'(strobe_cnt), 32'd1);
      chk("I_data",    32'(sd[0]),      32'h49);
      chk("I_err",     32'(se[0]),      32'h0);

      // Overflow: seven dots
      do_reset();
      for (int i = 0; i < 7; i++) begin
         press(500);
         if (i < 6) cyc_n(500);
      end
      cyc_n(100);
      chk("OVF_sym_sat", 32'(sym_count), 32'd6);
      cyc_n(3000);
      chk("OVF_strobes", 32'(strobe_cnt), 32'd1);
      chk("OVF_data",    32'(sd[0]),      32'h3F);
      chk("OVF_err",     32'(se[0]),      32'h1);
      chk("OVF_sym0",    32'(sym_count),  32'd0);
      chk("OVF_hold_data", 32'(char_data), 32'h3F);
      chk("OVF_hold_err",  32'(char_err),  32'h1);

      // Bouncing key, then a clean 500-cycle press; reset mid-press
      do_reset();
      for (int i = 0; i < 10; i++) begin
         button = ~button;
         cyc_n(2);
      end
      chk("DB_bounce_busy", 32'(busy),      32'd0);
      chk("DB_bounce_sym",  32'(sym_count), 32'd0);
      press(500);
      cyc_n(100);
      chk("DB_one_dot", 32'(sym_count), 32'd1);
      chk("DB_busy",    32'(busy),      32'd1);
      button = 1'b1;
      cyc_n(250);
      chk("MID_busy", 32'(busy), 32'd1);
      rst_n  = 1'b0;
      button = 1'b0;
      cyc_n(1);
      chk("MID_rst_data",  32'(char_data),  32'h00);
      chk("MID_rst_valid", 32'(char_valid), 32'h0);
      chk("MID_rst_err",   32'(char_err),   32'h0);
      chk("MID_rst_sym",   32'(sym_count),  32'h0);
      chk("MID_rst_busy",  32'(busy),       32'h0);
      rst_n = 1'b1;
      strobe_cnt = 0;
      cyc_n(3200);
      chk("MID_no_emit", 32'(strobe_cnt), 32'd0);
      chk("MID_idle",    32'(busy),       32'd0);

      // "E" followed by a long release
      do_reset();
      press(500);
      rel = cyc;
      cyc_n(8100);
      chk("E_data",    32'(sd[0]),        32'h45);
      chk("E_err",     32'(se[0]),        32'h0);
      chk("E_latency", 32'(sc[0] - rel),  32'd3008);
      chk("E_idle",    32'(busy),         32'd0);
`ifdef MORSE_WORD_SPACE_EN
      chk("WS_strobes", 32'(strobe_cnt),  32'd2);
      chk("WS_data",    32'(sd[1]),       32'h20);
      chk("WS_err",     32'(se[1]),       32'h0);
      chk("WS_spacing", 32'(sc[1] - sc[0]), 32'd4000);
`else
      chk("E_strobes", 32'(strobe_cnt), 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
